// File: rtl/rv32i_types.sv
// Shared RV32I core types: the branch-queue resolution bus and arbiter defaults.
package rv32i_types;

    // log2 of the branch queue depth; bq_id width follows it.
    localparam int BQ_DEPTH_BITS   = 3;

    // Default number of branch-resolution sources feeding the branch queue.
    localparam int BQ_RESOLVE_NREQ = 2;

    // Resolution write into the branch queue. ready=1 marks a valid write.
    typedef struct packed {
        logic                     ready;
        logic [BQ_DEPTH_BITS-1:0] bq_id;
        logic                     branch_taken;
        logic [31:0]              branch_target;
    } bq_bus_t;

endpackage

// File: rtl/bq_age_picker.sv
// Combinational oldest-first picker with round-robin tie-break among equal ages.
module bq_age_picker #(
    parameter int NREQ       = 2,
    parameter int DEPTH_BITS = 3,
    parameter int PTR_W      = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]                 cand,
    input  logic [NREQ-1:0][DEPTH_BITS-1:0] ages,
    input  logic [PTR_W-1:0]                rr_ptr,
    output logic [NREQ-1:0]                 grant,
    output logic [PTR_W-1:0]                win_idx
);

    logic                  found;
    logic [DEPTH_BITS-1:0] best_age;

    // Scan from rr_ptr upward; a strict less-than keeps the first hit among equal ages.
    always_comb begin
        found    = 1'b0;
        best_age = '0;
        win_idx  = '0;
        grant    = '0;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (cand[idx] && (!found || (ages[idx] < best_age))) begin
                found    = 1'b1;
                best_age = ages[idx];
                win_idx  = PTR_W'(idx);
            end
        end
        if (found) grant[win_idx] = 1'b1;
    end

endmodule

// File: rtl/bq_resolve_arbiter.sv
// Arbitrates branch-resolution sources onto the single branch-queue write port.
// Each source owns a one-entry slot; the oldest live slot (distance from tail)
// wins each cycle and is written to a registered bus. Stale slots are dropped.
//
// Handshake: slot i loads at a clock edge where req_valid[i] && req_ready[i];
// req_ready never depends on req_valid, and a source must hold req_data stable
// while req_valid is high and req_ready is low.
module bq_resolve_arbiter
    import rv32i_types::*;
#(
    parameter int NREQ       = BQ_RESOLVE_NREQ,
    parameter int DEPTH_BITS = BQ_DEPTH_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  bq_bus_t [NREQ-1:0]    req_data,
    output logic [NREQ-1:0]       req_ready,
    input  logic [DEPTH_BITS-1:0] tail_addr,
    input  logic [DEPTH_BITS:0]   elemcount,
    input  logic                  flush,
    output bq_bus_t               bus,
    output logic [7:0]            drop_count
);

    localparam int PTR_W = $clog2(NREQ);

    logic [NREQ-1:0]    slot_v_q, slot_v_d;
    bq_bus_t [NREQ-1:0] slot_d_q, slot_d_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    bq_bus_t            bus_q, bus_d;
    logic [7:0]         drop_count_q, drop_count_d;

    logic [NREQ-1:0][DEPTH_BITS-1:0] age;
    logic [NREQ-1:0]                 stale;
    logic [NREQ-1:0]                 cand;
    logic [NREQ-1:0]                 grant;
    logic [PTR_W-1:0]                win_idx;
    logic                            any_grant;

    // Age relative to the queue tail (wraps mod depth); slots beyond occupancy are stale.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            age[i]   = DEPTH_BITS'(slot_d_q[i].bq_id) - tail_addr;
            stale[i] = slot_v_q[i] & ({1'b0, age[i]} >= elemcount);
        end
        cand      = slot_v_q & ~stale;
        any_grant = |cand;
    end

    bq_age_picker #(
        .NREQ       (NREQ),
        .DEPTH_BITS (DEPTH_BITS),
        .PTR_W      (PTR_W)
    ) u_picker (
        .cand    (cand),
        .ages    (age),
        .rr_ptr  (rr_ptr_q),
        .grant   (grant),
        .win_idx (win_idx)
    );

    // A slot can take a new request when it is empty or is being vacated this cycle.
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_ready[i] = !flush & (!slot_v_q[i] | grant[i] | stale[i]);
        end
    end

    // Next state for slots, bus, round-robin pointer and the drop counter.
    always_comb begin
        int   n_stale;
        logic [8:0] drop_sum;
        slot_v_d     = slot_v_q;
        slot_d_d     = slot_d_q;
        rr_ptr_d     = rr_ptr_q;
        bus_d        = bus_q;
        bus_d.ready  = 1'b0;
        drop_count_d = drop_count_q;
        n_stale      = 0;
        drop_sum     = '0;
        if (flush) begin
            slot_v_d = '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (stale[i]) n_stale = n_stale + 1;
                if (req_valid[i] && req_ready[i]) begin
                    slot_v_d[i] = 1'b1;
                    slot_d_d[i] = req_data[i];
                end else if (grant[i] || stale[i]) begin
                    slot_v_d[i] = 1'b0;
                end
            end
            if (any_grant) begin
                bus_d       = slot_d_q[win_idx];
                bus_d.ready = 1'b1;
                rr_ptr_d    = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            end
            drop_sum = {1'b0, drop_count_q} + 9'(n_stale);
            drop_count_d = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
        end
    end

    // State registers; reset clears everything asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_v_q     <= '0;
            slot_d_q     <= '0;
            rr_ptr_q     <= '0;
            bus_q        <= '0;
            drop_count_q <= '0;
        end else begin
            slot_v_q     <= slot_v_d;
            slot_d_q     <= slot_d_d;
            rr_ptr_q     <= rr_ptr_d;
            bus_q        <= bus_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign bus        = bus_q;
    assign drop_count = drop_count_q;

endmodule

// File: doc/bq_resolve_arbiter.md
# bq_resolve_arbiter

Arbiter between NREQ branch-resolution sources (branch ALUs, JALR unit) and the single resolution write port (`bq_bus_t bus`) of the branch queue. Each source gets a one-entry holding slot with a valid/ready handshake. Every cycle the arbiter grants the oldest pending resolution, measured as distance from the queue tail, with round-robin tie-break, and drives it onto a registered bus. Stale resolutions for already-dequeued entries are discarded, and a flush empties all slots.

## Interface
- `NREQ`, 2: number of resolution sources, 2..4.
- `DEPTH_BITS`, 3: log2 of branch queue depth; must match the branch queue.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `req_valid` in [NREQ]: source i offers `req_data[i]`.
- `req_data` in bq_bus_t[NREQ]: `bq_id`, `branch_taken`, `branch_target`; the `ready` field is ignored.
- `req_ready` out [NREQ]: slot i can accept this cycle.
- `tail_addr` in DEPTH_BITS: branch queue tail, the oldest entry.
- `elemcount` in DEPTH_BITS+1: branch queue occupancy.
- `flush` in 1: synchronous pipeline flush.
- `bus` out bq_bus_t: registered write to the branch queue; `ready`=1 means a valid write.
- `drop_count` out 8: saturating count of discarded stale resolutions, for debug.

## Operation
- Slot i state: `slot_v[i]` and `slot_d[i]`.
- `req_ready[i] = !flush & (!slot_v[i] | grant[i] | stale[i])`.
- Slot i loads at the edge where `req_valid[i]` and `req_ready[i]` are both 1.
- Age: `age[i] = (slot_d[i].bq_id - tail_addr)` mod 2^DEPTH_BITS, computed as an unsigned DEPTH_BITS-wide subtract.
- Stale: `stale[i] = slot_v[i] & ({1'b0,age[i]} >= elemcount)`.
  - A stale slot is cleared at the next edge without a grant.
  - Each stale clear increments `drop_count`, saturating at 255.
  - If several slots go stale in one cycle, `drop_count` increments by that number.
- Candidates: slots with `slot_v & !stale`.
- Winner: the candidate with minimum age.
- Equal ages: the first candidate scanning from `rr_ptr` upward, modulo NREQ.
- At most one grant per cycle.
- On a grant to slot w:
  - `bus <= {ready:1, slot_d[w] fields}`.
  - `slot_v[w]` clears unless it is reloaded in the same edge.
  - `rr_ptr <= (w+1) mod NREQ`.
- No grant: `bus.ready <= 0`; other bus fields hold their previous values.
- `flush`: at the next edge all `slot_v <= 0` and `bus.ready <= 0`. Grants and loads in the flush cycle are suppressed; `rr_ptr` is kept.
- Reset (asynchronous, mid-operation allowed):
  - `slot_v`=0, `rr_ptr`=0, `bus`='0, `drop_count`=0.
  - `req_ready` is 1 for all i once `rst` is released, with `flush` low.

## Timing
- Minimum latency: `req_valid` accepted at edge E0, `bus.ready`=1 during the cycle after E1 (2 edges).
- Throughput: one resolution per cycle overall. With a single active source, that source sustains 1/cycle through the simultaneous drain and reload.
- Age and stale evaluate against the current-cycle `tail_addr` and `elemcount`. A dequeue in the same cycle as a grant is tolerated: the branch queue drops writes to freed entries.
- The bus is register-driven. There is no combinational path from `req_*` to `bus`.
- `req_ready` depends combinationally on `flush`, `tail_addr`, `elemcount` and slot state. It does not depend on `req_valid`.
- Wrap-around: `tail_addr`=6, `bq_id`=1 (depth 8) gives age 3, which is older than `bq_id`=5 (age 7).
- Empty queue (`elemcount`=0): every valid slot is stale.

## Structure
- `rv32i_types` already holds `bq_bus_t`.
- Add `BQ_RESOLVE_NREQ` to `rv32i_types` as the shared default for NREQ.
- Sub-module `bq_age_picker`, combinational: inputs candidate mask, ages, `rr_ptr`; outputs one-hot grant and winner index.
- Slot registers, `rr_ptr`, bus register and `drop_count` live in `bq_resolve_arbiter`.

## Test plan
- Reset, then source 0 sends `bq_id`=2, taken, target 0x40 with `tail`=0, `elemcount`=4 → `bus.ready`=1 with `bq_id`=2, target 0x40 exactly 2 edges later; `req_ready[0]` stays 1.
- Same cycle: src0 `bq_id`=5, src1 `bq_id`=1, `tail`=6, `elemcount`=8 → src1 granted first (age 3 < 7); src0 on the next cycle; `rr_ptr`=1 after the second grant.
- Both sources hold the same `bq_id`=3 → grants alternate src0, src1, src0 over 3 cycles starting from `rr_ptr`=0.
- `tail`=0, `elemcount`=2, src1 `bq_id`=4 → no bus write; slot cleared next edge; `drop_count`=1.
- `flush` with both slots full and `req_valid`=1 → `req_ready`=0 in that cycle; next cycle `slot_v`=0 and `bus.ready`=0; a new request is accepted in the following cycle.
- `rst` asserted low mid-grant → `bus.ready` falls immediately without waiting for a clock edge; `drop_count`=0; `req_ready` is 1 for all i after release.
